// File: rtl/filt_mac_sequencer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | filt_seq_pkg : shared types and helpers for the folded FIR sequencer        |
// | Revision     : 1.0                                                          |
// +----------------------------------------------------------------------------+
package filt_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DUMP = 2'd2
  } seq_state_t;

  localparam int OVR_CNT_W = 8;

  // Centre tap counts as a pair, then round up to whole multiplier groups.
  function automatic int num_steps(input int taps, input int pairs);
    return (((taps + 1) / 2) + pairs - 1) / pairs;
  endfunction

  function automatic int step_width(input int steps);
    return (steps > 1) ? $clog2(steps) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/filt_mac_sequencer_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | filt_mac_sequencer_if : sample-enable input and datapath control outputs    |
// | Revision              : 1.0                                                 |
// +----------------------------------------------------------------------------+
interface filt_mac_sequencer_if
  import filt_seq_pkg::*;
#(
  parameter int STEP_W = 2
);

  logic                 sam_clk_en;
  logic                 shift_en;
  logic [STEP_W-1:0]    step;
  logic                 acc_clr;
  logic                 acc_en;
  logic                 y_load;
  logic                 busy;
  logic                 overrun;
  logic [OVR_CNT_W-1:0] overrun_cnt;

  // master: the sequencer; slave: enable source plus filter datapath.
  modport master (
    input  sam_clk_en,
    output shift_en, step, acc_clr, acc_en, y_load, busy, overrun, overrun_cnt
  );

  modport slave (
    output sam_clk_en,
    input  shift_en, step, acc_clr, acc_en, y_load, busy, overrun, overrun_cnt
  );

endinterface
`default_nettype wire

// File: rtl/filt_mac_sequencer_sat_counter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sat_counter : up-counter that holds at all-ones, synchronous clear          |
// | Revision    : 1.0                                                           |
// +----------------------------------------------------------------------------+
module sat_counter
  import filt_seq_pkg::*;
#(
  parameter int WIDTH = OVR_CNT_W
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             i_inc,
  output logic      [WIDTH-1:0] o_count
);

  localparam logic [WIDTH-1:0] c_ONE = WIDTH'(1);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_inc && (r_count != '1)) begin
      r_count <= r_count + c_ONE;
    end
  end

  assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/filt_mac_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | filt_mac_sequencer : per-sample step sequencer for the folded SRRC/PPS FIR  |
// |   Optional macro FILT_SEQ_OVERRUN_CNT_EN enables the saturating overrun     |
// |   counter; otherwise overrun_cnt is tied to zero.                           |
// | Revision           : 1.0                                                    |
// +----------------------------------------------------------------------------+
module filt_mac_sequencer
  import filt_seq_pkg::*;
#(
  parameter int NUM_TAPS       = 21,
  parameter int PAIRS_PER_STEP = 3
) (
  input wire logic             sys_clk,
  input wire logic             reset,
  filt_mac_sequencer_if.master bus
);

  localparam int NUM_STEPS = num_steps(NUM_TAPS, PAIRS_PER_STEP);
  localparam int STEP_W    = step_width(NUM_STEPS);

  localparam logic [STEP_W-1:0] c_LAST_STEP = STEP_W'(NUM_STEPS - 1);
  localparam logic [STEP_W-1:0] c_STEP_ONE  = STEP_W'(1);

  if ((NUM_TAPS < 3) || ((NUM_TAPS % 2) == 0)) begin : g_chk_taps
    $error("filt_mac_sequencer: NUM_TAPS must be odd and at least 3");
  end

  if (PAIRS_PER_STEP < 1) begin : g_chk_pairs
    $error("filt_mac_sequencer: PAIRS_PER_STEP must be at least 1");
  end

  seq_state_t        r_state;
  seq_state_t        w_state_nxt;
  logic [STEP_W-1:0] r_step;
  logic [STEP_W-1:0] w_step_nxt;

  logic w_last;
  logic w_accept;
  logic w_reject;

  logic r_acc_clr, w_acc_clr_nxt;
  logic r_acc_en,  w_acc_en_nxt;
  logic r_y_load,  w_y_load_nxt;
  logic r_busy,    w_busy_nxt;
  logic r_overrun, w_overrun_nxt;

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_step    <= '0;
      r_acc_clr <= 1'b0;
      r_acc_en  <= 1'b0;
      r_y_load  <= 1'b0;
      r_busy    <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_step    <= w_step_nxt;
      r_acc_clr <= w_acc_clr_nxt;
      r_acc_en  <= w_acc_en_nxt;
      r_y_load  <= w_y_load_nxt;
      r_busy    <= w_busy_nxt;
      r_overrun <= w_overrun_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_step_nxt    = '0;
    w_acc_clr_nxt = 1'b0;
    w_acc_en_nxt  = 1'b0;
    w_y_load_nxt  = 1'b0;
    w_busy_nxt    = 1'b0;
    w_overrun_nxt = 1'b0;

    // A new sample is only taken once the current one has reached its last group.
    w_last   = (r_state == RUN) && (r_step == c_LAST_STEP);
    w_accept = bus.sam_clk_en && !reset &&
               ((r_state == IDLE) || (r_state == DUMP) || w_last);
    w_reject = bus.sam_clk_en && !reset && !w_accept;

    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        if (!w_last) begin
          w_step_nxt = r_step + c_STEP_ONE;
        end else if (w_accept) begin
          w_state_nxt = RUN;
        end else begin
          w_state_nxt = DUMP;
        end
      end
      DUMP: begin
        w_state_nxt = w_accept ? RUN : IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase

    // Registered outputs describe the cycle that follows this edge.
    w_acc_en_nxt  = (w_state_nxt == RUN);
    w_acc_clr_nxt = (w_state_nxt == RUN) && (w_step_nxt == '0);
    w_y_load_nxt  = w_last;
    w_busy_nxt    = (w_state_nxt != IDLE);
    w_overrun_nxt = w_reject;
  end

  assign bus.shift_en = w_accept;
  assign bus.step     = r_step;
  assign bus.acc_clr  = r_acc_clr;
  assign bus.acc_en   = r_acc_en;
  assign bus.y_load   = r_y_load;
  assign bus.busy     = r_busy;
  assign bus.overrun  = r_overrun;

`ifdef FILT_SEQ_OVERRUN_CNT_EN
  sat_counter #(
    .WIDTH (OVR_CNT_W)
  ) u_ovr_cnt (
    .clk     (sys_clk),
    .rst     (reset),
    .i_inc   (w_reject),
    .o_count (bus.overrun_cnt)
  );
`else
  assign bus.overrun_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_filt_mac_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_filt_mac_sequencer : directed bench for the folded FIR step sequencer    |
// | Revision              : 1.0                                                 |
// +----------------------------------------------------------------------------+
module tb_filt_mac_sequencer;

  localparam int STEP_W = 2;

`ifdef FILT_SEQ_OVERRUN_CNT_EN
  localparam int CNT_ON = 1;
`else
  localparam int CNT_ON = 0;
`endif

  logic sys_clk = 1'b0;
  logic reset;

  int n_checks = 0;
  int n_fail   = 0;
  int n_ovr;
  int acc;

  logic [31:0] s_shift [64];
  logic [31:0] s_step  [64];
  logic [31:0] s_clr   [64];
  logic [31:0] s_en    [64];
  logic [31:0] s_yl    [64];
  logic [31:0] s_busy  [64];
  logic [31:0] s_ovr   [64];
  logic [31:0] s_cnt   [64];

  filt_mac_sequencer_if #(.STEP_W(STEP_W)) bus ();

  filt_mac_sequencer #(
    .NUM_TAPS       (21),
    .PAIRS_PER_STEP (3)
  ) dut (
    .sys_clk (sys_clk),
    .reset   (reset),
    .bus     (bus)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Cycle c: inputs held from just after edge c-1, sampled at the falling edge,
  // captured by the DUT at edge c.
  task automatic run_seq(input logic [63:0] en_m, input logic [63:0] rst_m, input int ncyc);
    for (int c = 0; c < ncyc; c++) begin
      bus.sam_clk_en = en_m[c];
      reset          = rst_m[c];
      @(negedge sys_clk);
      s_shift[c] = 32'(bus.shift_en);
      s_step[c]  = 32'(bus.step);
      s_clr[c]   = 32'(bus.acc_clr);
      s_en[c]    = 32'(bus.acc_en);
      s_yl[c]    = 32'(bus.y_load);
      s_busy[c]  = 32'(bus.busy);
      s_ovr[c]   = 32'(bus.overrun);
      s_cnt[c]   = 32'(bus.overrun_cnt);
      @(posedge sys_clk);
      #1;
    end
    bus.sam_clk_en = 1'b0;
    reset          = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset          = 1'b1;
    bus.sam_clk_en = 1'b0;
    @(posedge sys_clk);
    #1;

    // Single enable at cycle 10
    run_seq(64'h400, 64'h7, 20);
    check("rst_step",    s_step[1], 0);
    check("rst_acc_en",  s_en[1],   0);
    check("rst_acc_clr", s_clr[1],  0);
    check("rst_y_load",  s_yl[1],   0);
    check("rst_busy",    s_busy[1], 0);
    check("rst_overrun", s_ovr[1],  0);
    check("rst_cnt",     s_cnt[3],  0);
    check("t1_shift9",   s_shift[9],  0);
    check("t1_shift10",  s_shift[10], 1);
    check("t1_shift11",  s_shift[11], 0);
    check("t1_busy10",   s_busy[10],  0);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("t1_step%0d", 11 + k),   s_step[11 + k], k);
      check($sformatf("t1_acc_en%0d", 11 + k), s_en[11 + k],   1);
    end
    check("t1_acc_clr11", s_clr[11], 1);
    check("t1_acc_clr12", s_clr[12], 0);
    check("t1_acc_en15",  s_en[15],  0);
    check("t1_y_load14",  s_yl[14],  0);
    check("t1_y_load15",  s_yl[15],  1);
    check("t1_y_load16",  s_yl[16],  0);
    check("t1_busy15",    s_busy[15], 1);
    check("t1_busy16",    s_busy[16], 0);

    // Back-to-back enables at 10, 14, 18
    run_seq(64'h44400, 64'h7, 26);
    acc = 0;
    for (int c = 0; c < 26; c++) acc += int'(s_ovr[c]);
    check("t2_overruns", acc, 0);
    acc = 0;
    for (int c = 0; c < 26; c++) acc += int'(s_en[c]);
    check("t2_acc_en_cycles", acc, 12);
    check("t2_shift14",   s_shift[14], 1);
    check("t2_shift18",   s_shift[18], 1);
    check("t2_y_load15",  s_yl[15],  1);
    check("t2_acc_clr15", s_clr[15], 1);
    check("t2_step15",    s_step[15], 0);
    check("t2_y_load19",  s_yl[19],  1);
    check("t2_acc_clr19", s_clr[19], 1);
    check("t2_y_load23",  s_yl[23],  1);
    check("t2_acc_clr23", s_clr[23], 0);
    check("t2_acc_en23",  s_en[23],  0);
    check("t2_busy23",    s_busy[23], 1);
    check("t2_busy24",    s_busy[24], 0);

    // Enable at 12 arrives mid-sequence and is rejected
    run_seq(64'h1400, 64'h7, 20);
    check("t3_shift10",   s_shift[10], 1);
    check("t3_shift12",   s_shift[12], 0);
    check("t3_overrun12", s_ovr[12], 0);
    check("t3_overrun13", s_ovr[13], 1);
    check("t3_overrun14", s_ovr[14], 0);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("t3_step%0d", 11 + k), s_step[11 + k], k);
    end
    check("t3_y_load15",  s_yl[15], 1);
    check("t3_cnt12",     s_cnt[12], 0);
    check("t3_cnt13",     s_cnt[13], CNT_ON ? 1 : 0);

    // Enable at 15 lands in DUMP and restarts immediately
    run_seq(64'h8400, 64'h7, 22);
    check("t4_shift15",   s_shift[15], 1);
    check("t4_y_load15",  s_yl[15],  1);
    check("t4_step16",    s_step[16], 0);
    check("t4_acc_clr16", s_clr[16], 1);
    check("t4_acc_en16",  s_en[16],  1);
    check("t4_y_load16",  s_yl[16],  0);
    check("t4_step19",    s_step[19], 3);
    check("t4_y_load20",  s_yl[20],  1);
    check("t4_busy20",    s_busy[20], 1);
    check("t4_busy21",    s_busy[21], 0);
    check("t4_overrun",   s_ovr[16], 0);

    // Reset pulse at 12 mid-RUN; enables at 1 and 12 coincide with reset
    run_seq(64'h5402, 64'h1007, 21);
    check("t5_shift1",    s_shift[1],  0);
    check("t5_step11",    s_step[11],  0);
    check("t5_step12",    s_step[12],  1);
    check("t5_shift12",   s_shift[12], 0);
    for (int c = 13; c < 15; c++) begin
      check($sformatf("t5_step%0d", c),    s_step[c], 0);
      check($sformatf("t5_acc_en%0d", c),  s_en[c],   0);
      check($sformatf("t5_acc_clr%0d", c), s_clr[c],  0);
      check($sformatf("t5_busy%0d", c),    s_busy[c], 0);
      check($sformatf("t5_overrun%0d", c), s_ovr[c],  0);
    end
    acc = 0;
    for (int c = 13; c < 19; c++) acc += int'(s_yl[c]);
    check("t5_no_y_load", acc, 0);
    check("t5_cnt13",     s_cnt[13], 0);
    check("t5_shift14",   s_shift[14], 1);
    check("t5_step15",    s_step[15], 0);
    check("t5_acc_clr15", s_clr[15], 1);
    check("t5_step16",    s_step[16], 1);
    check("t5_y_load19",  s_yl[19], 1);

    // Enable held high: three rejects per four cycles, 300 in total
    reset          = 1'b1;
    bus.sam_clk_en = 1'b0;
    @(posedge sys_clk);
    #1;
    reset = 1'b0;
    n_ovr = 0;
    for (int c = 0; c <= 401; c++) begin
      bus.sam_clk_en = (c <= 400);
      @(negedge sys_clk);
      if (bus.overrun === 1'b1) n_ovr++;
      if (c == 5) check("t6_cnt_early", 32'(bus.overrun_cnt), CNT_ON ? 3 : 0);
      @(posedge sys_clk);
      #1;
    end
    bus.sam_clk_en = 1'b0;
    @(negedge sys_clk);
    check("t6_overrun_pulses", n_ovr, 300);
    check("t6_cnt_sat", 32'(bus.overrun_cnt), CNT_ON ? 255 : 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/filt_mac_sequencer.md
# filt_mac_sequencer

Control sequencer for the time-shared (folded, symmetric) SRRC/PPS FIR datapath. It turns each `sam_clk_en` pulse into a fixed sequence of `sys_clk` steps, one per group of coefficient pairs, and drives the delay-line shift, accumulator clear/enable and output-register load. It sits between the clock-enable generator and the filter datapath, and it flags sample enables that arrive before the previous sample's sequence has finished.

## Interface
Parameters:
- `NUM_TAPS`, 21: filter length; odd, ≥3.
- `PAIRS_PER_STEP`, 3: multipliers available per `sys_clk` cycle.
- Derived values:
  - `NUM_PAIRS` = (NUM_TAPS+1)/2, with the centre tap counted as a pair.
  - `NUM_STEPS` = ceil(NUM_PAIRS/PAIRS_PER_STEP).
  - `STEP_W` = max(1, clog2(NUM_STEPS)).

Ports:
- `sys_clk` in 1: system clock; the only clock.
- `reset` in 1: synchronous, active-high.
- `sam_clk_en` in 1: one-cycle sample enable.
- `shift_en` out 1: combinational; sample accepted this cycle, so shift the delay line at this edge.
- `step` out STEP_W: registered; coefficient/tap group index for the current cycle.
- `acc_clr` out 1: registered; accumulator loads the products instead of adding them (high on step 0).
- `acc_en` out 1: registered; accumulator updates this cycle.
- `y_load` out 1: registered; output register captures the accumulator.
- `busy` out 1: registered; the FSM is in RUN or DUMP.
- `overrun` out 1: registered; one-cycle pulse when a `sam_clk_en` is rejected.
- `overrun_cnt` out 8: saturating count of rejected enables (see Configuration).

## Operation
- States: IDLE, RUN, DUMP. `step` counts 0..NUM_STEPS-1 in RUN only.
- Acceptance:
  - accept = `sam_clk_en` & (IDLE | DUMP | (RUN & `step`==NUM_STEPS-1)).
  - `shift_en` = accept.
  - reject = `sam_clk_en` & ~accept.
- Transitions:
  - IDLE & accept → RUN, step 0.
  - IDLE & ~accept → IDLE.
  - RUN & `step`<NUM_STEPS-1 → RUN, step+1. An enable arriving here is rejected and does not alter the sequence.
  - RUN & last step & accept → RUN, step 0.
  - RUN & last step & ~accept → DUMP.
  - DUMP & accept → RUN, step 0.
  - DUMP & ~accept → IDLE.
- Output values:
  - `acc_en`=1 in every RUN cycle; `acc_clr`=1 only in RUN step 0.
  - `y_load`=1 in the cycle immediately after any last step: either DUMP, or RUN step 0 of a back-to-back sample. The datapath captures the accumulator before the clear at the same edge, so a back-to-back `y_load` and `acc_clr` are legal together.
  - `step` reads 0 in IDLE and DUMP.
- Reject:
  - `overrun` pulses 1 in the cycle after the rejected enable.
  - The state sequence is unaffected.

## Timing
- Enable accepted at edge t: step 0 in cycle t+1, last step in cycle t+NUM_STEPS, `y_load` in cycle t+NUM_STEPS+1.
- Minimum sustainable enable period: NUM_STEPS cycles, with zero bubbles. With the defaults this is 4, matching the sys/4 sample rate.
- Reset values: all registered outputs 0, state IDLE, `overrun_cnt`=0.
- `shift_en` is 0 while `reset` is high.
- Reset asserted mid-RUN: the sequence is abandoned, with no `y_load` and no `overrun`.
- `sam_clk_en` in the same cycle as `reset`: ignored.

## Configuration
- Macro `FILT_SEQ_OVERRUN_CNT_EN`.
- Defined: `overrun_cnt` increments on each reject and saturates at 255. It clears only on `reset`.
- Undefined: the counter logic is removed and `overrun_cnt` is tied to 0. The port list is identical either way.

## Structure
- Package `filt_seq_pkg` holds:
  - the state enum type `seq_state_t` (IDLE/RUN/DUMP);
  - function `num_steps(taps, pairs)`;
  - constant `OVR_CNT_W`=8.
- One sub-module, `sat_counter` (parameterised width, synchronous clear, increment enable). It is instantiated only under `FILT_SEQ_OVERRUN_CNT_EN`.

## Test plan
- Defaults, with a single enable at cycle 10:
  - `shift_en`=1 at 10;
  - `step`=0,1,2,3 at cycles 11–14, `acc_clr` only at 11, `acc_en` at 11–14;
  - `y_load` at 15; IDLE at 16.
- Enables every 4 cycles (10, 14, 18):
  - no `overrun`, no DUMP gap;
  - `y_load`=`acc_clr`=1 at 15 and 19; DUMP at 23.
- Enables at 10 and 12: the second is rejected, giving `overrun`=1 at 13 and `shift_en`=0 at 12. The step sequence 11–14 is unchanged, and `overrun_cnt`=1 with the macro defined.
- Enable at 10, then enable at 15 (during DUMP): accepted, with `step`=0 at 16, `acc_clr`=1 at 16 and `y_load`=0 at 16.
- `reset` pulsed at cycle 12 mid-RUN: all outputs 0 from 13 onward, no `y_load`, and an enable at 14 starts step 0 at 15.
- With the macro defined, 300 rejected enables give `overrun_cnt`=255. Without the macro, the same stimulus gives `overrun_cnt`=0 with the `overrun` pulses unchanged.
